// File: rtl/expression_scheduler.sv
// Chooses which expression source drives the LCD pixel stream. Source changes
// take effect only on the first pixel of a frame, so the panel never shows a torn image.
module expression_scheduler #(
  parameter int LCD_W          = 132,
  parameter int LCD_H          = 162,
  parameter int HOLD_FRAMES    = 30,
  parameter int TIMEOUT_FRAMES = 240
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  addr_x,
  input  logic [7:0]  addr_y,
  input  logic [3:0]  req,
  input  logic        cancel,
  input  logic [15:0] src_data0,
  input  logic [15:0] src_data1,
  input  logic [15:0] src_data2,
  input  logic [15:0] src_data3,
  output logic [15:0] ram_data,
  output logic [1:0]  sel,
  output logic [1:0]  state_o,
  output logic [7:0]  frame_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_SHOW = 2'd2,
    S_RET  = 2'd3
  } state_t;

  state_t     state, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] pend_idx, win;
  logic       pend_vld, prev_origin;
  logic       origin, frame_start;
  logic       req_any, cancel_act, req_act, match_show;
  logic       pend_take, go_pend, timeout;
  logic       unused_req0;

  assign unused_req0 = req[0];

  // The in-panel qualifiers are always true at (0,0); coordinates outside the
  // panel can therefore never start a frame.
  assign origin      = (addr_x == 8'd0) && (addr_y == 8'd0) &&
                       (int'(addr_x) < LCD_W) && (int'(addr_y) < LCD_H);
  assign frame_start = origin && !prev_origin;

  always_comb begin
    win = 2'd0;
    if (req[3])      win = 2'd3;
    else if (req[2]) win = 2'd2;
    else if (req[1]) win = 2'd1;
  end

  assign req_any    = |req[3:1];
  assign cancel_act = cancel && (state != S_IDLE);
  assign req_act    = req_any && !cancel_act;
  assign match_show = req_act && (state == S_SHOW) && (win == sel_q);
  assign go_pend    = pend_vld && (pend_idx >= sel_q) && (int'(frame_cnt) >= HOLD_FRAMES);
  assign timeout    = int'(frame_cnt) >= TIMEOUT_FRAMES;

  always_comb begin
    state_d   = state;
    sel_d     = sel_q;
    pend_take = 1'b0;
    if (cancel_act) begin
      state_d = S_RET;
    end else begin
      case (state)
        S_IDLE: begin
          sel_d = 2'd0;
          if (pend_vld) state_d = S_PEND;
        end
        S_PEND: begin
          if (frame_start) begin
            state_d   = S_SHOW;
            sel_d     = pend_idx;
            pend_take = 1'b1;
          end
        end
        S_SHOW: begin
          if (go_pend)      state_d = S_PEND;
          else if (timeout) state_d = S_RET;
        end
        S_RET: begin
          if (frame_start) begin
            state_d = S_IDLE;
            sel_d   = 2'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sel_q       <= 2'd0;
      prev_origin <= 1'b1;
    end else begin
      state       <= state_d;
      sel_q       <= sel_d;
      prev_origin <= origin;
    end
  end

  // A consumed request frees the slot, so a request in the same cycle always loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_idx <= 2'd0;
    end else if (cancel_act) begin
      pend_vld <= 1'b0;
    end else if (req_act && !match_show && (!pend_vld || pend_take || win >= pend_idx)) begin
      pend_vld <= 1'b1;
      pend_idx <= win;
    end else if (pend_take) begin
      pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 8'd0;
    end else if (pend_take) begin
      frame_cnt <= 8'd0;
    end else if ((state == S_SHOW) && !cancel) begin
      if (match_show)
        frame_cnt <= 8'd0;
      else if (frame_start && (frame_cnt != 8'hFF))
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // The look-ahead select lets the first pixel of a new frame already come from the new source.
  assign sel = sel_d;

  always_comb begin
    case (sel)
      2'd0:    ram_data = src_data0;
      2'd1:    ram_data = src_data1;
      2'd2:    ram_data = src_data2;
      default: ram_data = src_data3;
    endcase
  end

  assign state_o = state;
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_expression_scheduler.sv
// Bench for expression_scheduler: directed scenarios plus randomized traffic,
// every cycle compared against a frame-level behavioural model.
module tb_expression_scheduler;

  localparam int HOLD    = 30;
  localparam int TMO     = 240;
  localparam int ST_IDLE = 0;
  localparam int ST_PEND = 1;
  localparam int ST_SHOW = 2;
  localparam int ST_RET  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  addr_x, addr_y;
  logic [3:0]  req;
  logic        cancel;
  logic [15:0] src_data0, src_data1, src_data2, src_data3;
  logic [15:0] ram_data;
  logic [1:0]  sel, state_o;
  logic [7:0]  frame_cnt;
  logic        busy;

  int checks_total  = 0;
  int checks_passed = 0;

  int         px, flen, req_rate, cancel_rate;
  bit         rand_mode;
  logic [3:0] req_q;
  logic       cancel_q;

  int m_state, m_sel, m_pi, m_cnt;
  bit m_pv, m_prev, m_fs;

  expression_scheduler #(
    .LCD_W(132), .LCD_H(162), .HOLD_FRAMES(HOLD), .TIMEOUT_FRAMES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr_x(addr_x), .addr_y(addr_y),
    .req(req), .cancel(cancel),
    .src_data0(src_data0), .src_data1(src_data1),
    .src_data2(src_data2), .src_data3(src_data3),
    .ram_data(ram_data), .sel(sel), .state_o(state_o),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 16'h%h, expected 16'h%h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] src_of(input int i);
    case (i)
      0:       return src_data0;
      1:       return src_data1;
      2:       return src_data2;
      default: return src_data3;
    endcase
  endfunction

  task automatic model_reset();
    m_state = ST_IDLE; m_sel = 0; m_pi = 0; m_cnt = 0;
    m_pv = 0; m_prev = 1; m_fs = 0;
  endtask

  // Checks this cycle's outputs against the frame rules, then advances the model past the next edge.
  task automatic model_eval();
    bit origin, cx, n_pv;
    int w, n_state, n_sel, n_pi, n_cnt;
    origin = (addr_x == 8'd0) && (addr_y == 8'd0);
    m_fs   = origin && !m_prev;
    if (req[3])      w = 3;
    else if (req[2]) w = 2;
    else if (req[1]) w = 1;
    else             w = 0;
    cx = cancel && (m_state != ST_IDLE);
    n_state = m_state; n_sel = m_sel; n_pi = m_pi; n_cnt = m_cnt; n_pv = m_pv;
    if (cx) begin
      n_state = ST_RET;
      n_pv    = 0;
    end else begin
      case (m_state)
        ST_IDLE: begin
          n_sel = 0;
          if (m_pv) n_state = ST_PEND;
        end
        ST_PEND: if (m_fs) begin
          n_state = ST_SHOW; n_sel = m_pi; n_cnt = 0; n_pv = 0;
        end
        ST_SHOW: begin
          if (m_fs && m_cnt < 255) n_cnt = m_cnt + 1;
          if (m_pv && m_pi >= m_sel && m_cnt >= HOLD) n_state = ST_PEND;
          else if (m_cnt >= TMO)                       n_state = ST_RET;
        end
        default: if (m_fs) begin
          n_state = ST_IDLE; n_sel = 0;
        end
      endcase
      if (w != 0) begin
        if (m_state == ST_SHOW && w == m_sel) n_cnt = 0;
        else if (!n_pv || w >= n_pi) begin
          n_pv = 1; n_pi = w;
        end
      end
    end
    checkOutput("sel",       16'(sel),       16'(n_sel));
    checkOutput("ram_data",  ram_data,       src_of(n_sel));
    checkOutput("state_o",   16'(state_o),   16'(m_state));
    checkOutput("frame_cnt", 16'(frame_cnt), 16'(m_cnt));
    checkOutput("busy",      16'(busy),      16'(m_state != ST_IDLE));
    m_state = n_state; m_sel = n_sel; m_pi = n_pi; m_cnt = n_cnt; m_pv = n_pv;
    m_prev  = origin;
  endtask

  // One pixel clock: drive the next raster position and pulses, then check at the falling edge.
  task automatic applyStimulus();
    @(posedge clk); #1;
    if (px == 0) begin
      addr_x = 8'd0; addr_y = 8'd0;
    end else if (rand_mode && $urandom_range(0, 7) == 0) begin
      if (px == 1) begin
        addr_x = 8'd0; addr_y = 8'd0;
      end else begin
        addr_x = 8'($urandom_range(132, 255)); addr_y = 8'($urandom_range(0, 255));
      end
    end else begin
      addr_x = 8'(px); addr_y = 8'd3;
    end
    req = req_q; cancel = cancel_q; req_q = 4'd0; cancel_q = 1'b0;
    if (rand_mode) begin
      src_data0 = 16'($urandom); src_data1 = 16'($urandom);
      src_data2 = 16'($urandom); src_data3 = 16'($urandom);
      if ($urandom_range(0, req_rate) == 0)    req = 4'($urandom_range(1, 15));
      if ($urandom_range(0, cancel_rate) == 0) cancel = 1'b1;
    end
    px++;
    if (px >= flen) begin
      px   = 0;
      flen = rand_mode ? int'($urandom_range(3, 10)) : 8;
    end
    @(negedge clk);
    model_eval();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req = 4'd0; cancel = 1'b0;
    #2;
    model_reset();
    checkOutput("rst_sel",   16'(sel),       16'd0);
    checkOutput("rst_busy",  16'(busy),      16'd0);
    checkOutput("rst_state", 16'(state_o),   16'd0);
    checkOutput("rst_cnt",   16'(frame_cnt), 16'd0);
    checkOutput("rst_ram",   ram_data,       src_data0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    model_eval();
  endtask

  task automatic next_frame();
    int n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!m_fs && n < 64);
  endtask

  task automatic wait_state(input int target, input int budget);
    int n = 0;
    while (int'(state_o) != target && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("wait_state", 16'(state_o), 16'(target));
  endtask

  task automatic directed_setup();
    rand_mode = 0;
    src_data0 = 16'h2935; src_data1 = 16'hF800; src_data2 = 16'h07E0; src_data3 = 16'h001F;
    do_reset();
    next_frame();
    next_frame();
  endtask

  initial begin
    int rates [3];
    rst_n = 1'b0; addr_x = 8'd5; addr_y = 8'd5; req = 4'd0; cancel = 1'b0;
    req_q = 4'd0; cancel_q = 1'b0; px = 1; flen = 8;
    req_rate = 15; cancel_rate = 200;
    model_reset();

    // Idle after reset: source 0 only.
    directed_setup();
    repeat (24) begin
      applyStimulus();
      checkOutput("idle_sel", 16'(sel), 16'd0);
      checkOutput("idle_ram", ram_data, 16'h2935);
    end

    // Mid-frame request switches exactly at the next origin.
    next_frame();
    repeat (2) applyStimulus();
    req_q = 4'b0010;
    applyStimulus();
    repeat (4) begin
      applyStimulus();
      checkOutput("r21_hold_sel", 16'(sel), 16'd0);
    end
    applyStimulus();
    checkOutput("r21_sel", 16'(sel), 16'd1);
    checkOutput("r21_ram", ram_data, 16'hF800);

    // Lower-index request waits out the timeout, then one idle frame.
    directed_setup();
    req_q = 4'b0110;
    applyStimulus();
    next_frame();
    checkOutput("r22_sel2", 16'(sel), 16'd2);
    checkOutput("r22_ram2", ram_data, 16'h07E0);
    repeat (5) next_frame();
    req_q = 4'b0010;
    applyStimulus();
    repeat (100) next_frame();
    checkOutput("r22_still2", 16'(sel), 16'd2);
    checkOutput("r22_show",   16'(state_o), 16'(ST_SHOW));
    wait_state(ST_RET, 3000);
    checkOutput("r22_cnt240", 16'(frame_cnt), 16'd240);
    next_frame();
    checkOutput("r22_sel0", 16'(sel), 16'd0);
    checkOutput("r22_ram0", ram_data, 16'h2935);
    next_frame();
    checkOutput("r22_sel1", 16'(sel), 16'd1);
    checkOutput("r22_ram1", ram_data, 16'hF800);

    // Higher-index request honours the minimum hold.
    directed_setup();
    req_q = 4'b0010;
    applyStimulus();
    next_frame();
    repeat (10) next_frame();
    req_q = 4'b1000;
    applyStimulus();
    wait_state(ST_PEND, 2000);
    checkOutput("r23_cnt30", 16'(frame_cnt), 16'd30);
    checkOutput("r23_sel1",  16'(sel), 16'd1);
    next_frame();
    checkOutput("r23_sel3", 16'(sel), 16'd3);
    checkOutput("r23_ram3", ram_data, 16'h001F);

    // Plain timeout, then cancel beating a simultaneous request.
    directed_setup();
    req_q = 4'b0100;
    applyStimulus();
    next_frame();
    wait_state(ST_RET, 3000);
    checkOutput("r24_cnt240", 16'(frame_cnt), 16'd240);
    checkOutput("r24_ret_sel", 16'(sel), 16'd2);
    next_frame();
    checkOutput("r24_sel0", 16'(sel), 16'd0);
    applyStimulus();
    checkOutput("r24_idle", 16'(state_o), 16'(ST_IDLE));
    req_q = 4'b0100;
    applyStimulus();
    next_frame();
    repeat (3) applyStimulus();
    req_q = 4'b1000; cancel_q = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("r24_cancel_ret", 16'(state_o), 16'(ST_RET));
    next_frame();
    applyStimulus();
    repeat (2) next_frame();
    checkOutput("r24_no_pend_state", 16'(state_o), 16'(ST_IDLE));
    checkOutput("r24_no_pend_sel",   16'(sel), 16'd0);

    // Reset mid-frame while showing with a request pending.
    directed_setup();
    req_q = 4'b0010;
    applyStimulus();
    next_frame();
    repeat (2) next_frame();
    req_q = 4'b1000;
    applyStimulus();
    repeat (2) applyStimulus();
    do_reset();
    repeat (3) begin
      next_frame();
      checkOutput("r25_sel", 16'(sel), 16'd0);
    end
    checkOutput("r25_state", 16'(state_o), 16'(ST_IDLE));

    // Randomized traffic at three request densities.
    rates[0] = 15; rates[1] = 300; rates[2] = 4000;
    rand_mode = 1;
    cancel_rate = 200;
    for (int i = 0; i < 3; i++) begin
      req_rate = rates[i];
      if (i == 1) do_reset();
      repeat (10000) applyStimulus();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/expression_scheduler.md
EXPRESSION_SCHEDULER -- requirements
Module: expression_scheduler

Interface
REQ-001 Parameters (name, default, meaning): LCD_W, 132, pixel columns; LCD_H, 162, pixel rows; HOLD_FRAMES, 30, minimum frames an expression stays shown; TIMEOUT_FRAMES, 240, frames before automatic return to idle, always >= HOLD_FRAMES.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- addr_x, in, 8, current pixel column from the LCD driver
- addr_y, in, 8, current pixel row from the LCD driver
- req, in, 4, one-cycle expression request pulses; bit 0 is ignored (idle)
- cancel, in, 1, one-cycle pulse that forces a return to idle
- src_data0..src_data3, in, 16 each, RGB565 pixel from sources 0..3; source 0 is idle
- ram_data, out, 16, pixel sent to the LCD driver
- sel, out, 2, index of the displayed source
- state_o, out, 2, FSM state
- frame_cnt, out, 8, frames since the current expression was shown, saturating at 255
- busy, out, 1, high when state is not S_IDLE

Function
REQ-003 Single clock domain; all registers update on the rising edge of clk.
REQ-004 frame_start: a one-cycle pulse when (addr_x, addr_y) == (0, 0) in the current cycle and != (0, 0) in the previous cycle; it is the only point at which sel may change (tear-free switching).
REQ-005 Arbitration: the winner is the highest set bit of req[3:1]; priority order 3 > 2 > 1.
REQ-006 Pending register pend_vld/pend_idx: loaded with the winner whenever req[3:1] != 0; a later request overwrites the earlier one only if its index is >= pend_idx.
REQ-007 ram_data is purely combinational: src_data[sel]; zero latency from the source inputs.
REQ-008 FSM states:
- S_IDLE = 0
- S_PEND = 1
- S_SHOW = 2
- S_RET = 3
REQ-009 S_IDLE: sel = 0; when pend_vld is set -> S_PEND.
REQ-010 S_PEND: on frame_start -> S_SHOW.
- sel <= pend_idx.
- Clear pend_vld.
- frame_cnt <= 0.
REQ-011 S_SHOW: frame_cnt increments on each frame_start, saturating at 255.
- pend_vld with pend_idx >= sel, and frame_cnt >= HOLD_FRAMES -> S_PEND.
- frame_cnt >= TIMEOUT_FRAMES -> S_RET.
- If both conditions hold in the same cycle, S_PEND wins.
REQ-012 S_RET: on frame_start -> S_IDLE and sel <= 0; a request arriving in S_RET is kept pending and taken from S_IDLE.
REQ-013 A request for an index lower than sel while in S_SHOW stays pending until timeout, then is taken after the return to idle.
REQ-014 cancel in any state except S_IDLE -> S_RET, and pend_vld is cleared; if cancel and a req pulse arrive in the same cycle, cancel wins and the req is discarded.
REQ-015 A req that matches the currently shown index in S_SHOW resets frame_cnt to 0 and does not set pend_vld.
REQ-016 The block is insensitive to addr values >= LCD_W or >= LCD_H; only the (0, 0) transition matters.
REQ-017 busy = (state != S_IDLE); state_o mirrors the state register.

Reset
REQ-018 rst_n low, asynchronously and at any time including mid-frame, forces:
- state = S_IDLE, sel = 0, ram_data = src_data0
- pend_vld = 0, pend_idx = 0
- frame_cnt = 0, busy = 0
- previous-origin flag = 1, so no spurious frame_start on the first cycle after release
REQ-019 After rst_n deasserts, operation resumes on the first clock edge; no request is remembered across reset.

Verification
REQ-020 Reset, then sweep addr over frames with src_data0..src_data3 = 16'h2935, 16'hF800, 16'h07E0, 16'h001F -> sel = 0 and ram_data = 16'h2935 on every cycle.
REQ-021 Pulse req = 4'b0010 mid-frame -> sel stays 0 until the next (0, 0) transition, then sel = 1 and ram_data = 16'hF800 in that same cycle.
REQ-022 Pulse req = 4'b0110 in one cycle -> sel = 2 after the next frame_start; a req[1] pulse 5 frames later is held pending until timeout, then sel = 0 for one frame, then sel = 1.
REQ-023 While showing index 1, pulse req[3] at frame 10 -> sel stays 1 until frame_cnt = 30, then switches to 3 at the next frame_start.
REQ-024 Hold index 2 without further requests -> frame_cnt reaches 240, state goes to S_RET, and sel = 0 at the following frame_start; a cancel and a req[3] pulse in the same cycle -> S_RET with pend_vld = 0.
REQ-025 Assert rst_n = 0 mid-frame while in S_SHOW with a request pending -> immediate sel = 0 and busy = 0, and no switch occurs after release.
